// File: rtl/v6502_pkg.sv
// Shared constants for the v6502 fetch path: default widths, reset vector and
// the decoder's instruction-length encoding.
package v6502_pkg;

  localparam int          ADDR_W_DEFAULT   = 16;
  localparam int          MAX_INST_LEN     = 3;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    CLEN_NONE = 2'd0,
    CLEN_1    = 2'd1,
    CLEN_2    = 2'd2,
    CLEN_3    = 2'd3
  } clen_e;

  // A consume is honoured only for a nonzero length that the queue can cover.
  function automatic logic clen_legal(input logic [1:0] len, input logic [7:0] avail);
    return (len != CLEN_NONE) && ({6'd0, len} <= avail);
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_byte_ring.sv
// Byte ring buffer: DEPTH x 8 storage, one write port at the tail, an
// advance-by-n port at the head and a zero-masked 3-byte head window.
module byte_ring #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_adv_en,
  input  logic [1:0]    i_adv_n,
  output logic [CW-1:0] o_count,
  output logic [7:0]    o_byte0,
  output logic [7:0]    o_byte1,
  output logic [7:0]    o_byte2
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_add;
  logic [CW-1:0] w_sub;

  assign w_add = i_wr_en  ? CW'(1'b1)    : {CW{1'b0}};
  assign w_sub = i_adv_en ? CW'(i_adv_n) : {CW{1'b0}};

  // Pointer and occupancy update; power-of-two DEPTH gives free wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (i_wr_en)  r_tail <= r_tail + PW'(1'b1);
      if (i_adv_en) r_head <= r_head + PW'(i_adv_n);
      r_count <= r_count + w_add - w_sub;
    end
  end

  // Storage write; stale entries are never visible because the window is masked.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_tail] <= i_wr_data;
  end

  assign o_count = r_count;
  assign o_byte0 = (r_count > {CW{1'b0}}) ? r_mem[r_head]              : 8'h00;
  assign o_byte1 = (r_count > CW'(1'b1))  ? r_mem[r_head + PW'(1'b1)]  : 8'h00;
  assign o_byte2 = (r_count > CW'(2'd2))  ? r_mem[r_head + PW'(2'd2)]  : 8'h00;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps one byte read in flight ahead of the
// decoder and exposes a 3-byte window at head_pc; flush redirects fetch.
module inst_prefetch_queue
  import v6502_pkg::*;
#(
  parameter  int                DEPTH    = 8,
  parameter  int                ADDR_W   = ADDR_W_DEFAULT,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  localparam int                CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        q_byte0,
  output logic [7:0]        q_byte1,
  output logic [7:0]        q_byte2,
  output logic [CW-1:0]     q_count,
  output logic [ADDR_W-1:0] head_pc,
  input  logic              consume,
  input  logic [1:0]        consume_len,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc
);

  logic              r_pending;
  logic              r_drop;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_head_pc;
  logic              w_issue;
  logic              w_ack;
  logic              w_wr;
  logic              w_cons;

  // A new request starts from registered state only, so it can be acked in
  // the same cycle it first appears; an open request holds its own address.
  assign w_issue  = !rst && !r_pending && (q_count < CW'(DEPTH));
  assign mem_req  = r_pending || w_issue;
  assign mem_addr = r_pending ? r_req_addr : r_fetch_pc;
  assign w_ack    = mem_req && mem_ack;
  assign w_wr     = w_ack && !r_drop && !flush;
  assign w_cons   = consume && !flush && clen_legal(consume_len, 8'(q_count));
  assign head_pc  = r_head_pc;

  byte_ring #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (flush),
    .i_wr_en   (w_wr),
    .i_wr_data (mem_rdata),
    .i_adv_en  (w_cons),
    .i_adv_n   (consume_len),
    .o_count   (q_count),
    .o_byte0   (q_byte0),
    .o_byte1   (q_byte1),
    .o_byte2   (q_byte2)
  );

  // Fetch control: outstanding/drop flags, fetch pointer and head address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_drop     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_head_pc  <= RESET_PC;
    end else begin
      r_pending <= mem_req && !mem_ack;
      if (w_issue) r_req_addr <= r_fetch_pc;
      if (flush) begin
        r_drop     <= mem_req && !mem_ack;
        r_fetch_pc <= flush_pc;
        r_head_pc  <= flush_pc;
      end else begin
        if (w_ack)  r_drop     <= 1'b0;
        if (w_wr)   r_fetch_pc <= r_fetch_pc + ADDR_W'(1'b1);
        if (w_cons) r_head_pc  <= r_head_pc + ADDR_W'(consume_len);
      end
    end
  end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Parametrised instruction prefetch queue for the v6502 core. It sits between the memory port and the decoder. It fetches opcode and operand bytes ahead of execution into a DEPTH-entry circular buffer and presents a 3-byte window at the head, so the decoder can consume a complete 1-, 2- or 3-byte instruction in one cycle. A branch or jump flushes the queue and redirects fetch.

## Interface
- DEPTH, 8: queue entries in bytes; power of two, ≥4.
- ADDR_W, 16: fetch address width.
- RESET_PC, 16'h0000: fetch address after reset.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_W  address of the requested byte.
- mem_ack  in  1  read completes this cycle.
- mem_rdata  in  8  read data, valid when mem_ack is high.
- q_byte0 / q_byte1 / q_byte2  out  8 each  head bytes (opcode, op1, op2).
- q_count  out  $clog2(DEPTH+1)  valid bytes in the queue.
- head_pc  out  ADDR_W  address of q_byte0.
- consume  in  1  decoder retires the head instruction.
- consume_len  in  2  instruction length, 1..3.
- flush  in  1  discard the queue and redirect fetch.
- flush_pc  in  ADDR_W  new fetch and head address.

## Operation
- Reset values: mem_req=0, mem_addr=RESET_PC, q_count=0, head_pc=RESET_PC, q_byte0..2=8'h00, fetch pointer=RESET_PC, drop flag=0.
- Fetch:
  - At most one request is outstanding.
  - A new request is issued when no request is pending and q_count < DEPTH.
  - mem_req and mem_addr stay stable until the cycle mem_ack is high.
  - On ack, the byte is written at the tail and the fetch pointer increments, unless the drop flag is set.
- Head window: q_byteN shows entry head+N when N < q_count, otherwise 8'h00.
- Consume:
  - Legal only when 1 ≤ consume_len ≤ q_count.
  - Effect: head advances by consume_len, head_pc += consume_len, q_count -= consume_len.
  - consume_len=0, or consume_len > q_count, is ignored with no state change.
- Write and consume in the same cycle: q_count_next = q_count + 1 − consume_len.
- Flush (highest priority; overrides a write and a consume in the same cycle):
  - q_count=0; head and tail pointers reset; head_pc=flush_pc; fetch pointer=flush_pc.
  - If a request is outstanding and not acked this cycle, mem_req stays high until ack, drop=1, and that returned byte is discarded. drop then clears.
  - A flush in the same cycle as an ack discards that byte.
- Wrap-around:
  - Ring pointers wrap modulo DEPTH.
  - The fetch pointer and head_pc wrap from 2^ADDR_W−1 to 0.
- Full: q_count=DEPTH means no new request. A request already in flight still lands, because issue is gated at q_count < DEPTH while nothing is pending.
- Empty: the window reads zeros and consume is ignored.
- rst mid-transfer: all state returns to reset values immediately. An ack arriving in the rst cycle is ignored.

## Timing
- The first mem_req rises in the first cycle after rst deasserts.
- A zero-wait ack is allowed: ack in the same cycle mem_req first rises.
- A byte acked in cycle N is visible on q_byte*/q_count in cycle N+1.
- Back-to-back requests: the next mem_req with the incremented address is asserted in cycle N+1 after an ack in cycle N. Peak throughput is one byte per cycle.
- Outputs are registered state; the window is a mux of the ring, with no combinational path from consume or flush to the outputs in the same cycle.
- After a flush in cycle F with no request outstanding, mem_req for flush_pc is asserted in F+1.

## Structure
- Package v6502_pkg holds:
  - ADDR_W default.
  - MAX_INST_LEN=3.
  - The consume_len encoding constants.
  - The shared RESET_PC constant.
- Sub-module byte_ring: DEPTH×8 storage with head/tail pointers, write port, advance-by-n port, and a 3-byte read window.
- Fetch control (pending/drop flags and fetch pointer) lives in the top module.

## Test plan
- Reset, zero-wait memory returning A9 05 8D 00 02 from 0000 → q_count reaches 5. Window A9 05 8D. head_pc=0000.
- With the window holding A9 05 8D, consume_len=2 in the same cycle as an ack → q_count 5→4. Window 8D 00 02. head_pc=0002.
- With memory acking each request after 3 cycles, the queue fills to DEPTH=8 → mem_req stays low at q_count=8 and re-asserts the cycle after one consume_len=1.
- Flush flush_pc=C000 while a request to 0009 is outstanding, ack arriving 2 cycles later with EA → EA is discarded, q_count stays 0, and the next mem_addr is C000.
- Fetch pointer at FFFE with RESET_PC=FFFE → addresses FFFE, FFFF, 0000 are requested in order, and head_pc wraps to 0000 after consuming 2 bytes.
- consume_len=3 with q_count=2, and separately consume_len=0 → no change to q_count, head_pc or the window.
